alu_muldiv: RTL and testbench

Multi-cycle RV32M multiply/divide unit, parametrised in data width, sitting beside the single-cycle ALU in the execute stage. It accepts one operation per start pulse, iterates radix-2 (shift-add / restoring shift-subtract), and returns a registered result with a one-cycle done pulse. Divide-by-zero and signed-overflow cases bypass iteration. The hazard unit stalls the pipeline on Busy_o.

---
 rtl/muldiv_pkg.sv | 44 ++++
 rtl/muldiv_step.sv | 62 ++++++
 rtl/alu_muldiv.sv | 192 +++++++++++++++++++
 tb/tb_alu_muldiv.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared types and helpers for the RV32M multiply/divide unit.
//                Holds the funct3 operation encoding, the FSM state type, and
//                the functions that classify an operation by kind and by
//                operand signedness.
//  Revision    : 1.0  initial release
// ============================================================================
package muldiv_pkg;

    // funct3 encoding of the M-extension operations
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_div(input muldiv_op_t op);
        return (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
    endfunction

    function automatic logic is_signed_a(input muldiv_op_t op);
        return (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    endfunction

    function automatic logic is_signed_b(input muldiv_op_t op);
        return (op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
    endfunction

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : One combinational radix-2 iteration on unsigned magnitudes.
//                Multiply mode: shift-add on a {hi,lo} product pair, with the
//                multiplier consumed from the LSB of lo.
//                Divide mode: restoring shift-subtract; hi is the partial
//                remainder, lo shifts the dividend out and quotient bits in.
//  Ports       : i_div_mode  0 = multiply step, 1 = divide step
//                i_acc_hi    product high word / partial remainder
//                i_acc_lo    product low word  / dividend-quotient shifter
//                i_operand   multiplicand magnitude / divisor magnitude
//                o_acc_hi    next hi
//                o_acc_lo    next lo
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_step #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 i_div_mode,
    input  logic [DATAWIDTH-1:0] i_acc_hi,
    input  logic [DATAWIDTH-1:0] i_acc_lo,
    input  logic [DATAWIDTH-1:0] i_operand,
    output logic [DATAWIDTH-1:0] o_acc_hi,
    output logic [DATAWIDTH-1:0] o_acc_lo
);

    logic [DATAWIDTH-1:0] w_addend;
    logic [DATAWIDTH:0]   w_sum;
    logic [DATAWIDTH:0]   w_trial;
    logic [DATAWIDTH+1:0] w_diff;
    logic                 w_fits;

    // Multiply: add the multiplicand when the current multiplier bit is set,
    // then shift the whole product right by one (carry enters the top).
    assign w_addend = i_acc_lo[0] ? i_operand : '0;
    assign w_sum    = {1'b0, i_acc_hi} + {1'b0, w_addend};

    // Divide: the (DATAWIDTH+1)-bit partial remainder after shifting in the
    // next dividend bit, and its trial difference against the divisor.
    assign w_trial  = {i_acc_hi, i_acc_lo[DATAWIDTH-1]};
    assign w_diff   = {1'b0, w_trial} - {2'b00, i_operand};
    // A successful subtraction always leaves a value below the divisor, so
    // both upper bits are zero exactly when no borrow occurred.
    assign w_fits   = ~(w_diff[DATAWIDTH+1] | w_diff[DATAWIDTH]);

    always_comb begin
        o_acc_hi = {w_sum[DATAWIDTH:1]};
        o_acc_lo = {w_sum[0], i_acc_lo[DATAWIDTH-1:1]};
        if (i_div_mode) begin
            if (w_fits) begin
                o_acc_hi = w_diff[DATAWIDTH-1:0];
                o_acc_lo = {i_acc_lo[DATAWIDTH-2:0], 1'b1};
            end else begin
                o_acc_hi = w_trial[DATAWIDTH-1:0];
                o_acc_lo = {i_acc_lo[DATAWIDTH-2:0], 1'b0};
            end
        end
    end

endmodule : muldiv_step
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv
//  Description : Multi-cycle RV32M multiply/divide unit. Operands are reduced
//                to magnitudes on accept, iterated one radix-2 step per cycle,
//                then sign-corrected in a single FIX cycle. Divide-by-zero
//                and signed-overflow divisions finish at the accept edge.
//  Ports       : clk       clock, rising edge
//                rst       synchronous active-high reset
//                Start_i   request, sampled in IDLE or DONE
//                Op_i      funct3 operation code
//                SrcA_i    rs1 (multiplicand / dividend)
//                SrcB_i    rs2 (multiplier / divisor)
//                Flush_i   abort the current operation
//                Result_o  registered result, held until overwritten
//                Busy_o    high while iterating or correcting
//                Done_o    one-cycle pulse when Result_o is new
//  Revision    : 1.0  initial release
// ============================================================================
module alu_muldiv
    import muldiv_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Start_i,
    input  logic [2:0]           Op_i,
    input  logic [DATAWIDTH-1:0] SrcA_i,
    input  logic [DATAWIDTH-1:0] SrcB_i,
    input  logic                 Flush_i,
    output logic [DATAWIDTH-1:0] Result_o,
    output logic                 Busy_o,
    output logic                 Done_o
);

    localparam int CNT_WIDTH = $clog2(DATAWIDTH) + 1;
    localparam logic [DATAWIDTH-1:0] c_most_neg = {1'b1, {(DATAWIDTH-1){1'b0}}};
    localparam logic [DATAWIDTH-1:0] c_all_ones = '1;

    state_t                 r_state;
    muldiv_op_t             r_op;
    logic                   r_sign_a;
    logic                   r_sign_b;
    logic [DATAWIDTH-1:0]   r_operand;
    logic [DATAWIDTH-1:0]   r_acc_hi;
    logic [DATAWIDTH-1:0]   r_acc_lo;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [DATAWIDTH-1:0]   r_result;
    logic                   r_busy;
    logic                   r_done;

    muldiv_op_t             w_op;
    logic                   w_sign_a;
    logic                   w_sign_b;
    logic [DATAWIDTH-1:0]   w_mag_a;
    logic [DATAWIDTH-1:0]   w_mag_b;
    logic                   w_b_zero;
    logic                   w_div_ovf;
    logic                   w_fast;
    logic [DATAWIDTH-1:0]   w_fast_result;
    logic [DATAWIDTH-1:0]   w_step_hi;
    logic [DATAWIDTH-1:0]   w_step_lo;
    logic [2*DATAWIDTH-1:0] w_prod;
    logic [2*DATAWIDTH-1:0] w_prod_fix;
    logic [DATAWIDTH-1:0]   w_quo_fix;
    logic [DATAWIDTH-1:0]   w_rem_fix;
    logic [DATAWIDTH-1:0]   w_fix_result;

    // ---------------------------------------------------------------- accept
    assign w_op     = muldiv_op_t'(Op_i);
    assign w_sign_a = is_signed_a(w_op) & SrcA_i[DATAWIDTH-1];
    assign w_sign_b = is_signed_b(w_op) & SrcB_i[DATAWIDTH-1];
    // Negating the most-negative value yields the same bit pattern, which is
    // its correct unsigned magnitude.
    assign w_mag_a  = w_sign_a ? -SrcA_i : SrcA_i;
    assign w_mag_b  = w_sign_b ? -SrcB_i : SrcB_i;

    assign w_b_zero  = (SrcB_i == '0);
    assign w_div_ovf = (w_op == OP_DIV || w_op == OP_REM) &&
                       (SrcA_i == c_most_neg) && (SrcB_i == c_all_ones);
    assign w_fast    = is_div(w_op) && (w_b_zero || w_div_ovf);

    always_comb begin
        w_fast_result = '0;
        if (w_b_zero) begin
            w_fast_result = (w_op == OP_DIV || w_op == OP_DIVU) ? c_all_ones : SrcA_i;
        end else if (w_op == OP_DIV) begin
            w_fast_result = SrcA_i;
        end
    end

    // ------------------------------------------------------------- iteration
    muldiv_step #(
        .DATAWIDTH (DATAWIDTH)
    ) u_step (
        .i_div_mode (is_div(r_op)),
        .i_acc_hi   (r_acc_hi),
        .i_acc_lo   (r_acc_lo),
        .i_operand  (r_operand),
        .o_acc_hi   (w_step_hi),
        .o_acc_lo   (w_step_lo)
    );

    // ------------------------------------------------------- sign correction
    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = (r_sign_a ^ r_sign_b) ? -w_prod : w_prod;
    assign w_quo_fix  = (r_sign_a ^ r_sign_b) ? -r_acc_lo : r_acc_lo;
    assign w_rem_fix  = r_sign_a ? -r_acc_hi : r_acc_hi;

    always_comb begin
        w_fix_result = w_prod_fix[DATAWIDTH-1:0];
        case (r_op)
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_result = w_prod_fix[2*DATAWIDTH-1:DATAWIDTH];
            OP_DIV,  OP_DIVU:             w_fix_result = w_quo_fix;
            OP_REM,  OP_REMU:             w_fix_result = w_rem_fix;
            default:                      w_fix_result = w_prod_fix[DATAWIDTH-1:0];
        endcase
    end

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_MUL;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_operand <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (Flush_i) begin
            // Abort wins over everything, including a coincident start.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (Start_i) begin
                        r_op     <= w_op;
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        if (w_fast) begin
                            r_result <= w_fast_result;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            // Multiply keeps the multiplier in lo and adds the
                            // multiplicand; divide shifts the dividend out of lo.
                            r_operand <= is_div(w_op) ? w_mag_b : w_mag_a;
                            r_acc_lo  <= is_div(w_op) ? w_mag_a : w_mag_b;
                            r_acc_hi  <= '0;
                            r_cnt     <= CNT_WIDTH'(DATAWIDTH);
                            r_busy    <= 1'b1;
                            r_state   <= ST_CALC;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                    r_cnt    <= r_cnt - CNT_WIDTH'(1);
                    if (r_cnt == CNT_WIDTH'(1)) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_result <= w_fix_result;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Result_o = r_result;
    assign Busy_o   = r_busy;
    assign Done_o   = r_done;

endmodule : alu_muldiv
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_muldiv
//  Description : Self-checking bench for alu_muldiv at 32 bits. A behavioural
//                model built on 64-bit arithmetic predicts Result_o, Busy_o
//                and Done_o every cycle; directed vectors add literal result
//                and latency expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_muldiv;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          Start_i;
    logic [2:0]    Op_i;
    logic [DW-1:0] SrcA_i;
    logic [DW-1:0] SrcB_i;
    logic          Flush_i;
    logic [DW-1:0] Result_o;
    logic          Busy_o;
    logic          Done_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t_acc    = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    alu_muldiv #(
        .DATAWIDTH (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Start_i  (Start_i),
        .Op_i     (Op_i),
        .SrcA_i   (SrcA_i),
        .SrcB_i   (SrcB_i),
        .Flush_i  (Flush_i),
        .Result_o (Result_o),
        .Busy_o   (Busy_o),
        .Done_o   (Done_o)
    );

    // ---------------------------------------------------------------- model
    function automatic logic [31:0] ref_op(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] q;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic [63:0]        p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'b000: begin p = ua * ub; return p[31:0];  end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                q = sa / sb;
                return q[31:0];
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                q = sa % sb;
                return q[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        return op[2] && ((b == 0) ||
               ((op == 3'b100 || op == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Remaining busy cycles of the operation in flight (0 = idle/done).
    int          m_left = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_res  = '0;
    logic [31:0] m_pend = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_left <= 0; m_busy <= 1'b0; m_done <= 1'b0; m_res <= '0;
        end else if (Flush_i) begin
            m_left <= 0; m_busy <= 1'b0; m_done <= 1'b0;
        end else if (m_left > 1) begin
            m_left <= m_left - 1; m_done <= 1'b0;
        end else if (m_left == 1) begin
            m_left <= 0; m_busy <= 1'b0; m_done <= 1'b1; m_res <= m_pend;
        end else if (Start_i) begin
            if (is_fast(Op_i, SrcA_i, SrcB_i)) begin
                m_res  <= ref_op(Op_i, SrcA_i, SrcB_i);
                m_done <= 1'b1;
            end else begin
                m_pend <= ref_op(Op_i, SrcA_i, SrcB_i);
                m_left <= DW + 1;
                m_busy <= 1'b1;
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_busy",   32'(Busy_o), 32'(m_busy));
            chk("cmp_done",   32'(Done_o), 32'(m_done));
            chk("cmp_result", Result_o,    m_res);
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start_i = 1'b1; Op_i = op; SrcA_i = a; SrcB_i = b;
        @(negedge clk);
        Start_i = 1'b0;
        t_acc   = cyc;
    endtask

    task automatic wait_done(input string nm, input logic [31:0] exp, input int lat);
        int n;
        n = 0;
        while (Done_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done"},    32'(Done_o),              32'd1);
        chk({nm, "_latency"}, 32'(cyc - t_acc + 1),     32'(lat));
        chk({nm, "_result"},  Result_o,                 exp);
    endtask

    task automatic run(input string nm, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
        @(negedge clk);
        chk({nm, "_model"}, ref_op(op, a, b), exp);
        issue(op, a, b);
        wait_done(nm, exp, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; Start_i = 1'b0; Op_i = 3'b000; SrcA_i = '0; SrcB_i = '0; Flush_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_result", Result_o,      32'h0);
        chk("rst_busy",   32'(Busy_o),   32'h0);
        chk("rst_done",   32'(Done_o),   32'h0);
        chk_en = 1'b1;
        rst    = 1'b0;

        // Iterated operations
        run("mul",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run("mulh",   3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34);
        run("mulhu",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run("mulhsu", 3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34);
        run("div",    3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
        run("rem",    3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
        run("div_nb", 3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        run("rem_nb", 3'b110, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 34);
        run("divu",   3'b101, 32'd100,        32'd7,         32'd14,        34);
        run("remu",   3'b111, 32'd100,        32'd7,         32'd2,         34);

        // Fast paths
        run("divu_z", 3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        run("rem_z",  3'b110, 32'd5,          32'd0,         32'd5,         1);
        run("div_ov", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("rem_ov", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1);

        // Start while busy is ignored
        @(negedge clk);
        issue(3'b101, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        Start_i = 1'b1; Op_i = 3'b000; SrcA_i = 32'd3; SrcB_i = 32'd4;
        @(negedge clk);
        Start_i = 1'b0;
        wait_done("ignore", 32'd14, 34);

        // Back-to-back accepts in the DONE cycle
        issue(3'b111, 32'd100, 32'd7);
        wait_done("b2b_remu", 32'd2, 34);
        issue(3'b101, 32'd5, 32'd0);
        wait_done("b2b_fast", 32'hFFFF_FFFF, 1);
        issue(3'b000, 32'd6, 32'd7);
        wait_done("b2b_mul", 32'd42, 34);

        // Flush mid-operation
        @(negedge clk);
        issue(3'b000, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        Flush_i = 1'b1;
        @(negedge clk);
        Flush_i = 1'b0;
        chk("flush_busy", 32'(Busy_o), 32'h0);
        repeat (40) @(negedge clk);
        chk("flush_result", Result_o, 32'd42);

        // Flush and start together: flush wins
        Flush_i = 1'b1; Start_i = 1'b1; Op_i = 3'b101; SrcA_i = 32'd5; SrcB_i = 32'd0;
        @(negedge clk);
        Flush_i = 1'b0; Start_i = 1'b0;
        chk("flush_start_done", 32'(Done_o), 32'h0);
        repeat (3) @(negedge clk);
        chk("flush_start_result", Result_o, 32'd42);

        // Reset mid-multiply
        issue(3'b000, 32'd9, 32'd9);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy",   32'(Busy_o), 32'h0);
        chk("rst_mid_done",   32'(Done_o), 32'h0);
        chk("rst_mid_result", Result_o,    32'h0);
        run("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 34);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_muldiv
`default_nettype wire
